ahb_lite_master: RTL and testbench

- Single-outstanding AHB-lite initiator that turns core load/store requests into AHB-lite SINGLE transfers.
- Drives the peripheral bus that the memory-mapped slaves (dtube, etc.) respond to, and returns read data and error status to the core.
- Aborts transfers that stall beyond a timeout, so a slave holding HREADY low (e.g. on an address error) cannot hang the core.

---
 rtl/ahb_lite_master.sv | 174 +++++++++++++++++
 tb/tb_ahb_lite_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-lite initiator: core load/store requests become SINGLE transfers,
// with alignment checking and a stall timeout so a wedged slave cannot hang the core.
module ahb_lite_master #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [DATA_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [1:0]        HTRANS,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP
);

  localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0]       HRESP_ERROR   = 2'b01;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t              r_state, w_state;
  logic [1:0]          r_htrans, w_htrans;
  logic [DATA_W-1:0]   r_haddr, w_haddr;
  logic                r_hwrite, w_hwrite;
  logic [2:0]          r_hsize, w_hsize;
  logic [DATA_W-1:0]   r_hwdata, w_hwdata;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic                r_rsp_valid, w_rsp_valid;
  logic                r_rsp_err, w_rsp_err;
  logic                r_rsp_timeout, w_rsp_timeout;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata;

  function automatic logic f_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return (size > 3'd2) ||
           ((size == 3'd1) && addr_lo[0]) ||
           ((size == 3'd2) && (addr_lo != 2'b00));
  endfunction

  always_comb begin
    w_state       = r_state;
    w_htrans      = r_htrans;
    w_haddr       = r_haddr;
    w_hwrite      = r_hwrite;
    w_hsize       = r_hsize;
    w_hwdata      = r_hwdata;
    w_wdata       = r_wdata;
    w_cnt         = r_cnt;
    w_rsp_valid   = 1'b0;
    w_rsp_err     = 1'b0;
    w_rsp_timeout = 1'b0;
    w_rsp_rdata   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (f_misaligned(req_size, req_addr[1:0])) begin
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
          end else begin
            w_state  = S_ADDR;
            w_htrans = HTRANS_NONSEQ;
            w_haddr  = req_addr;
            w_hwrite = req_write;
            w_hsize  = req_size;
            w_wdata  = req_wdata;
            w_cnt    = '0;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          w_state  = S_DATA;
          w_htrans = HTRANS_IDLE;
          w_hwdata = r_hwrite ? r_wdata : '0;
          w_cnt    = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state       = S_IDLE;
          w_htrans      = HTRANS_IDLE;
          w_cnt         = '0;
          w_rsp_valid   = 1'b1;
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        // An error response wins regardless of HREADY: the slave may never release it.
        if (HRESP == HRESP_ERROR) begin
          w_state     = S_IDLE;
          w_cnt       = '0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
        end else if (HREADY) begin
          w_state     = S_IDLE;
          w_cnt       = '0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_hwrite ? '0 : HRDATA;
        end else if (r_cnt == CNT_LAST) begin
          w_state       = S_IDLE;
          w_cnt         = '0;
          w_rsp_valid   = 1'b1;
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_htrans      <= HTRANS_IDLE;
      r_haddr       <= '0;
      r_hwrite      <= 1'b0;
      r_hsize       <= 3'd0;
      r_hwdata      <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_state       <= w_state;
      r_htrans      <= w_htrans;
      r_haddr       <= w_haddr;
      r_hwrite      <= w_hwrite;
      r_hsize       <= w_hsize;
      r_hwdata      <= w_hwdata;
      r_wdata       <= w_wdata;
      r_cnt         <= w_cnt;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_err     <= w_rsp_err;
      r_rsp_timeout <= w_rsp_timeout;
      r_rsp_rdata   <= w_rsp_rdata;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign HADDR       = r_haddr;
  assign HWRITE      = r_hwrite;
  assign HSIZE       = r_hsize;
  assign HBURST      = 3'b000;
  assign HTRANS      = r_htrans;
  assign HMASTLOCK   = 1'b0;
  assign HWDATA      = r_hwdata;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: zero-wait write, waited read, error response,
// address-phase timeout, misalignment and mid-transfer reset, against hand-computed values.
module tb_ahb_lite_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  int n_chk  = 0;
  int n_pass = 0;

  ahb_lite_master #(.DATA_W(32), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    logic bad;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 2'b00;
    step(); step();
    chk("rst_htrans",    {30'd0, HTRANS}, 32'd0);
    chk("rst_haddr",     HADDR, 32'd0);
    chk("rst_hwdata",    HWDATA, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("tied_hburst",   {29'd0, HBURST}, 32'd0);
    chk("tied_hmastlock",{31'd0, HMASTLOCK}, 32'd0);
    rst = 1'b0;
    step();

    // Zero-wait write
    issue(1'b1, 32'h1000_0000, 3'd2, 32'h0000_000A);
    chk("wr_c1_htrans", {30'd0, HTRANS}, 32'd2);
    chk("wr_c1_hwrite", {31'd0, HWRITE}, 32'd1);
    chk("wr_c1_haddr",  HADDR, 32'h1000_0000);
    chk("wr_c1_hsize",  {29'd0, HSIZE}, 32'd2);
    chk("wr_c1_ready",  {31'd0, req_ready}, 32'd0);
    step();
    chk("wr_c2_htrans", {30'd0, HTRANS}, 32'd0);
    chk("wr_c2_hwdata", HWDATA, 32'h0000_000A);
    chk("wr_c2_rspv",   {31'd0, rsp_valid}, 32'd0);
    step();
    chk("wr_c3_rspv",   {31'd0, rsp_valid}, 32'd1);
    chk("wr_c3_err",    {31'd0, rsp_err}, 32'd0);
    chk("wr_c3_rdata",  rsp_rdata, 32'd0);
    chk("wr_c3_ready",  {31'd0, req_ready}, 32'd1);
    step();
    chk("wr_c4_rspv",   {31'd0, rsp_valid}, 32'd0);

    // Read with two data-phase wait states
    issue(1'b0, 32'h1000_0004, 3'd2, 32'hDEAD_BEEF);
    chk("rd_c1_hwrite", {31'd0, HWRITE}, 32'd0);
    step();
    chk("rd_c2_hwdata", HWDATA, 32'd0);
    HREADY = 1'b0;
    step();
    chk("rd_w1_rspv",   {31'd0, rsp_valid}, 32'd0);
    step();
    chk("rd_w2_rspv",   {31'd0, rsp_valid}, 32'd0);
    HREADY = 1'b1; HRDATA = 32'h0000_0005;
    step();
    chk("rd_rspv",      {31'd0, rsp_valid}, 32'd1);
    chk("rd_rdata",     rsp_rdata, 32'h0000_0005);
    chk("rd_err",       {31'd0, rsp_err}, 32'd0);
    HRDATA = 32'h0;
    step();
    chk("rd_after_rdata", rsp_rdata, 32'd0);

    // Error response with HREADY held low
    issue(1'b0, 32'h1000_0008, 3'd2, 32'h0);
    step();
    HREADY = 1'b0; HRESP = 2'b01;
    step();
    chk("er_rspv",      {31'd0, rsp_valid}, 32'd1);
    chk("er_err",       {31'd0, rsp_err}, 32'd1);
    chk("er_tmo",       {31'd0, rsp_timeout}, 32'd0);
    chk("er_htrans",    {30'd0, HTRANS}, 32'd0);
    HREADY = 1'b1; HRESP = 2'b00;
    step();
    chk("er_after_rspv",{31'd0, rsp_valid}, 32'd0);
    chk("er_after_err", {31'd0, rsp_err}, 32'd0);

    // Address-phase stall until timeout
    HREADY = 1'b0;
    issue(1'b1, 32'h1000_000C, 3'd2, 32'h1234_5678);
    chk("to_c1_htrans", {30'd0, HTRANS}, 32'd2);
    bad = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      if (rsp_valid !== 1'b0 || HTRANS !== 2'b10 || HADDR !== 32'h1000_000C) bad = 1'b1;
    end
    chk("to_hold_15", {31'd0, bad}, 32'd0);
    step();
    chk("to_rspv",      {31'd0, rsp_valid}, 32'd1);
    chk("to_err",       {31'd0, rsp_err}, 32'd1);
    chk("to_tmo",       {31'd0, rsp_timeout}, 32'd1);
    chk("to_htrans",    {30'd0, HTRANS}, 32'd0);
    chk("to_ready",     {31'd0, req_ready}, 32'd1);
    HREADY = 1'b1;
    step();
    chk("to_after_tmo", {31'd0, rsp_timeout}, 32'd0);

    // Misaligned requests: immediate error, never a NONSEQ
    issue(1'b1, 32'h1000_0002, 3'd2, 32'h0);
    chk("mis_w_rspv",   {31'd0, rsp_valid}, 32'd1);
    chk("mis_w_err",    {31'd0, rsp_err}, 32'd1);
    chk("mis_w_tmo",    {31'd0, rsp_timeout}, 32'd0);
    chk("mis_w_htrans", {30'd0, HTRANS}, 32'd0);
    chk("mis_w_ready",  {31'd0, req_ready}, 32'd1);
    issue(1'b0, 32'h1000_0001, 3'd1, 32'h0);
    chk("mis_h_err",    {31'd0, rsp_err}, 32'd1);
    issue(1'b0, 32'h1000_0000, 3'd3, 32'h0);
    chk("mis_sz3_err",  {31'd0, rsp_err}, 32'd1);
    chk("mis_sz3_htr",  {30'd0, HTRANS}, 32'd0);
    step();
    chk("mis_idle_htr", {30'd0, HTRANS}, 32'd0);
    // Aligned halfword at addr[1]=1 is legal
    issue(1'b0, 32'h1000_0002, 3'd1, 32'h0);
    chk("half_ok_htr",  {30'd0, HTRANS}, 32'd2);
    step(); step();
    chk("half_ok_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("half_ok_err",  {31'd0, rsp_err}, 32'd0);

    // Reset asserted during the data phase
    issue(1'b1, 32'h1000_0010, 3'd2, 32'h0000_0077);
    step();
    chk("rs_data_hwd",  HWDATA, 32'h0000_0077);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_htrans",    {30'd0, HTRANS}, 32'd0);
    chk("rs_haddr",     HADDR, 32'd0);
    chk("rs_hwdata",    HWDATA, 32'd0);
    chk("rs_hwrite",    {31'd0, HWRITE}, 32'd0);
    chk("rs_rspv",      {31'd0, rsp_valid}, 32'd0);
    chk("rs_ready",     {31'd0, req_ready}, 32'd1);
    step();
    chk("rs_rspv2",     {31'd0, rsp_valid}, 32'd0);
    issue(1'b1, 32'h1000_0014, 3'd2, 32'h0000_0033);
    chk("rs_new_htr",   {30'd0, HTRANS}, 32'd2);
    step();
    chk("rs_new_hwd",   HWDATA, 32'h0000_0033);
    // Back-to-back: accept a read in the completion cycle
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000_0018; req_size = 3'd2;
    HRDATA = 32'hCAFE_0001;
    step();
    chk("b2b_rspv",     {31'd0, rsp_valid}, 32'd1);
    chk("b2b_ready",    {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    chk("b2b_htrans",   {30'd0, HTRANS}, 32'd2);
    chk("b2b_haddr",    HADDR, 32'h1000_0018);
    step(); step();
    chk("b2b_rd_rspv",  {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rd_data",  rsp_rdata, 32'hCAFE_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
